// File: rtl/dmg_soc_pkg.sv
// Shared DMG SoC definitions: OAM DMA state encoding and fixed bus addresses.
package dmg_soc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARM   = 2'd1,
      ST_XFER  = 2'd2,
      ST_DRAIN = 2'd3
   } dma_state_t;

   localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
   localparam logic [15:0] OAM_BASE     = 16'hFE00;
   localparam int          DMA_LEN_DEF  = 160;

endpackage

// File: rtl/dmg_oam_dma_ctr.sv
// 8-bit OAM DMA beat counter: load-to-zero, count-up enable, terminal-count flag.
module dmg_oam_dma_ctr
   import dmg_soc_pkg::*;
#(
   parameter logic [7:0] TC_VAL = 8'd159
) (
   input  logic       clk,
   input  logic       res,
   input  logic       load,
   input  logic       en,
   output logic [7:0] count,
   output logic       tc
);

   always_ff @(posedge clk or posedge res) begin
      if (res)       count <= 8'h00;
      else if (load) count <= 8'h00;
      else if (en)   count <= count + 8'd1;
   end

   assign tc = (count == TC_VAL);

endmodule

// File: rtl/dmg_oam_dma.sv
// OAM DMA controller: copies DMA_LEN bytes from {page,8'h00} into OAM, one byte per M-cycle.
// Build option DMG_OAM_DMA_ECHO_EN maps source pages E0..FF onto the WRAM echo (page - 8'h20).
//   state    | meaning
//   ST_IDLE  | no copy in progress
//   ST_ARM   | start delay after FF46 write, bus not requested
//   ST_XFER  | requesting bus; each granted cycle reads one byte, writes the previous one
//   ST_DRAIN | final OAM write of the last captured byte
module dmg_oam_dma
   import dmg_soc_pkg::*;
#(
   parameter int DMA_LEN     = DMA_LEN_DEF,
   parameter int START_DELAY = 1
) (
   input  logic        clk,
   input  logic        res,
   input  logic        reg_we,
   input  logic [7:0]  reg_wdata,
   output logic [7:0]  reg_rdata,
   output logic        bus_req,
   input  logic        bus_gnt,
   output logic [15:0] src_addr,
   output logic        src_rd,
   input  logic [7:0]  src_data,
   output logic [7:0]  oam_addr,
   output logic        oam_wr,
   output logic [7:0]  oam_wdata,
   output logic        dma_active
);

   localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);
   localparam logic [1:0] DLY_LOAD = (START_DELAY > 0) ? 2'(START_DELAY - 1) : 2'd0;
   localparam dma_state_t START_ST = (START_DELAY > 0) ? ST_ARM : ST_XFER;

   dma_state_t state_q, state_d;
   logic [7:0] page_q;
   logic [7:0] data_q;
   logic [1:0] dly_q, dly_d;
   logic [7:0] idx;
   logic       tc;
   logic       idx_load, idx_en;
   logic       beat;
   logic [7:0] eff_page;

`ifdef DMG_OAM_DMA_ECHO_EN
   assign eff_page = (page_q >= 8'hE0) ? page_q - 8'h20 : page_q;
`else
   assign eff_page = page_q;
`endif

   dmg_oam_dma_ctr #(.TC_VAL(LAST_IDX)) u_ctr (
      .clk   (clk),
      .res   (res),
      .load  (idx_load),
      .en    (idx_en),
      .count (idx),
      .tc    (tc)
   );

   assign beat = (state_q == ST_XFER) && bus_gnt;

   always_comb begin
      state_d  = state_q;
      dly_d    = dly_q;
      idx_load = 1'b0;
      idx_en   = 1'b0;
      case (state_q)
         ST_ARM: begin
            if (dly_q == 2'd0) state_d = ST_XFER;
            else               dly_d   = dly_q - 2'd1;
         end
         ST_XFER: begin
            // The last beat is not counted so idx can never wrap past LAST_IDX.
            if (beat && tc) state_d = ST_DRAIN;
            idx_en = beat && !tc;
         end
         ST_DRAIN: state_d = ST_IDLE;
         default:  state_d = state_q;
      endcase
      if (reg_we) begin
         state_d  = START_ST;
         dly_d    = DLY_LOAD;
         idx_load = 1'b1;
         idx_en   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q <= ST_IDLE;
         dly_q   <= 2'd0;
         page_q  <= 8'h00;
         data_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         dly_q   <= dly_d;
         if (reg_we) page_q <= reg_wdata;
         if (beat)   data_q <= src_data;
      end
   end

   // A restart in the same cycle discards whatever OAM write was pending.
   assign oam_wr     = ((beat && (idx != 8'h00)) || (state_q == ST_DRAIN)) && !reg_we;
   assign oam_addr   = !oam_wr ? 8'h00 : (state_q == ST_DRAIN) ? LAST_IDX : idx - 8'd1;
   assign oam_wdata  = data_q;
   assign src_rd     = beat;
   assign src_addr   = {eff_page, idx};
   assign bus_req    = (state_q == ST_XFER);
   assign dma_active = (state_q != ST_IDLE);
   assign reg_rdata  = page_q;

endmodule

// File: tb/tb_dmg_oam_dma.sv
// Scoreboard bench for dmg_oam_dma: expected OAM writes queued at stimulus, checked at each oam_wr.
module tb_dmg_oam_dma;

   logic clk = 1'b0;
   logic res = 1'b1;
   always #5 clk = ~clk;

   logic        we_a = 1'b0, gnt_a = 1'b1, rd_a, owr_a, req_a, act_a;
   logic [7:0]  wdata_a = 8'h00, rdata_a, sdata_a, oaddr_a, owdata_a;
   logic [15:0] saddr_a;
   logic        we_b = 1'b0, gnt_b = 1'b1, rd_b, owr_b, req_b, act_b;
   logic [7:0]  wdata_b = 8'h00, rdata_b, sdata_b, oaddr_b, owdata_b;
   logic [15:0] saddr_b;

   assign sdata_a = saddr_a[7:0] ^ 8'h5A;
   assign sdata_b = saddr_b[7:0] ^ 8'h5A;

   dmg_oam_dma #(.DMA_LEN(160), .START_DELAY(1)) dut_a (
      .clk(clk), .res(res), .reg_we(we_a), .reg_wdata(wdata_a), .reg_rdata(rdata_a),
      .bus_req(req_a), .bus_gnt(gnt_a), .src_addr(saddr_a), .src_rd(rd_a), .src_data(sdata_a),
      .oam_addr(oaddr_a), .oam_wr(owr_a), .oam_wdata(owdata_a), .dma_active(act_a));

   dmg_oam_dma #(.DMA_LEN(1), .START_DELAY(0)) dut_b (
      .clk(clk), .res(res), .reg_we(we_b), .reg_wdata(wdata_b), .reg_rdata(rdata_b),
      .bus_req(req_b), .bus_gnt(gnt_b), .src_addr(saddr_b), .src_rd(rd_b), .src_data(sdata_b),
      .oam_addr(oaddr_b), .oam_wr(owr_b), .oam_wdata(owdata_b), .dma_active(act_b));

   int n_chk = 0, n_err = 0;
   int cyc = 0, c0 = 0;
   int first_rd = -1, first_act = -1, last_act = -1, last_wr = -1;
   logic [15:0] first_addr = 16'h0000;
   logic [7:0]  exp_page = 8'h00;
   logic [15:0] sb_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push_run(input int last);
      for (int i = 0; i <= last; i++) sb_q.push_back({8'(i), 8'(i) ^ 8'h5A});
   endtask

   task automatic start_a(input logic [7:0] pg, input logic [7:0] src_pg);
      we_a = 1'b1; wdata_a = pg; c0 = cyc;
      tick;
      we_a = 1'b0; exp_page = src_pg;
      first_rd = -1; first_act = -1;
   endtask

   task automatic wait_idx_a(input logic [7:0] v);
      logic found = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (req_a && saddr_a[7:0] == v) begin found = 1'b1; break; end
         tick;
      end
      chk("wait_idx", found, 1);
   endtask

   task automatic wait_done_a;
      logic done = 1'b0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (!act_a) begin done = 1'b1; break; end
      end
      chk("done_timeout", done, 1);
      chk("sb_left", sb_q.size(), 0);
      tick;
   endtask

   always @(negedge clk) begin
      logic [15:0] e;
      if (act_a) begin
         if (first_act < 0) first_act = cyc;
         last_act = cyc;
      end
      if (rd_a) begin
         if (first_rd < 0) begin first_rd = cyc; first_addr = saddr_a; end
         chk("src_page", saddr_a[15:8], exp_page);
      end
      if (owr_a) begin
         last_wr = cyc;
         chk("sb_has_entry", sb_q.size() != 0, 1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("oam_addr", oaddr_a, e[15:8]);
            chk("oam_wdata", owdata_a, e[7:0]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_act", act_a, 0);
      chk("rst_req", req_a, 0);
      chk("rst_oam_wr", owr_a, 0);
      chk("rst_rdata", rdata_a, 0);
      chk("rst_src_addr", saddr_a, 0);
      tick;
      res = 1'b0;
      tick;

      // 1: plain copy, grant always high
      push_run(159);
      start_a(8'hC1, 8'hC1);
      chk("t1_rdata", rdata_a, 8'hC1);
      wait_done_a;
      chk("t1_first_act", first_act - c0, 1);
      chk("t1_first_rd", first_rd - c0, 2);
      chk("t1_first_addr", first_addr, 16'hC100);
      chk("t1_last_wr", last_wr - c0, 162);
      chk("t1_last_act", last_act - c0, 162);

      // 2: three-cycle grant stall at idx 40
      push_run(159);
      start_a(8'hC1, 8'hC1);
      wait_idx_a(8'd40);
      gnt_a = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("t2_stall_rd", rd_a, 0);
         chk("t2_stall_wr", owr_a, 0);
         chk("t2_stall_idx", saddr_a[7:0], 8'd40);
         tick;
      end
      gnt_a = 1'b1;
      wait_done_a;
      chk("t2_last_wr", last_wr - c0, 165);

      // 3: restart with a new page at idx 80
      push_run(78);
      start_a(8'hC0, 8'hC0);
      wait_idx_a(8'd80);
      we_a = 1'b1; wdata_a = 8'hD0; c0 = cyc;
      @(negedge clk);
      chk("t3_wr_suppressed", owr_a, 0);
      tick;
      we_a = 1'b0; exp_page = 8'hD0; first_rd = -1;
      push_run(159);
      @(negedge clk);
      chk("t3_act_held", act_a, 1);
      chk("t3_arm_no_req", req_a, 0);
      wait_done_a;
      chk("t3_first_rd", first_rd - c0, 2);
      chk("t3_first_addr", first_addr, 16'hD000);
      chk("t3_rdata", rdata_a, 8'hD0);

      // 4: echo-region page
      push_run(159);
`ifdef DMG_OAM_DMA_ECHO_EN
      start_a(8'hFE, 8'hDE);
`else
      start_a(8'hFE, 8'hFE);
`endif
      chk("t4_rdata_start", rdata_a, 8'hFE);
      wait_done_a;
`ifdef DMG_OAM_DMA_ECHO_EN
      chk("t4_first_addr", first_addr, 16'hDE00);
`else
      chk("t4_first_addr", first_addr, 16'hFE00);
`endif
      chk("t4_rdata_end", rdata_a, 8'hFE);

      // 5: reset mid-copy; a write during reset is ignored
      push_run(98);
      start_a(8'h33, 8'h33);
      wait_idx_a(8'd100);
      res = 1'b1;
      #1;
      chk("t5_act", act_a, 0);
      chk("t5_req", req_a, 0);
      chk("t5_rd", rd_a, 0);
      chk("t5_wr", owr_a, 0);
      chk("t5_src_addr", saddr_a, 0);
      chk("t5_oam_addr", oaddr_a, 0);
      chk("t5_oam_wdata", owdata_a, 0);
      chk("t5_rdata", rdata_a, 0);
      we_a = 1'b1; wdata_a = 8'h77;
      tick;
      tick;
      we_a = 1'b0;
      res = 1'b0;
      @(negedge clk);
      chk("t5_we_ignored_rdata", rdata_a, 0);
      chk("t5_we_ignored_act", act_a, 0);
      chk("t5_sb_left", sb_q.size(), 0);
      tick;

      // 6: DMA_LEN=1, START_DELAY=0
      we_b = 1'b1; wdata_b = 8'h12;
      tick;
      we_b = 1'b0;
      @(negedge clk);
      chk("t6_c1_rd", rd_b, 1);
      chk("t6_c1_addr", saddr_b, 16'h1200);
      chk("t6_c1_wr", owr_b, 0);
      chk("t6_c1_act", act_b, 1);
      @(negedge clk);
      chk("t6_c2_rd", rd_b, 0);
      chk("t6_c2_wr", owr_b, 1);
      chk("t6_c2_oam_addr", oaddr_b, 8'h00);
      chk("t6_c2_oam_wdata", owdata_b, 8'h5A);
      chk("t6_c2_act", act_b, 1);
      @(negedge clk);
      chk("t6_c3_act", act_b, 0);
      chk("t6_c3_wr", owr_b, 0);
      chk("t6_rdata", rdata_b, 8'h12);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
